// File: rtl/tdes_frame_sched.sv
// Frame scheduler: command + 8-byte block from the I2C slave RX stream
// drives one Triple-DES operation; the 64-bit result goes to the TX FIFO.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready   received byte stream (handshake)
//   frame_abort                 STOP/Sr seen mid-frame
//   des_start/des_decrypt       DES start pulse and direction
//   des_block_in                packed 64-bit input block
//   des_busy/des_done           DES core status / completion pulse
//   des_block_out               DES result, valid with des_done
//   write_enable/write_data     TX FIFO write port
//   fifo_full                   TX FIFO full
//   busy/err/frame_count        status: not idle, error pulse, frames done
module tdes_frame_sched #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        frame_abort,
  output logic        des_start,
  output logic        des_decrypt,
  output logic [63:0] des_block_in,
  input  logic        des_busy,
  input  logic        des_done,
  input  logic [63:0] des_block_out,
  output logic        write_enable,
  output logic [7:0]  write_data,
  input  logic        fifo_full,
  output logic        busy,
  output logic        err,
  output logic [7:0]  frame_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_q, dec_d;
  logic [63:0]   blk_q, blk_d;
  logic [63:0]   res_q, res_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [7:0]    fcnt_q, fcnt_d;

  logic [2:0]    nidx;
  logic [5:0]    rx_sh;
  logic [5:0]    tx_sh;
  logic [63:0]   tx_shift;

  // Byte k sits at bit offset 8*(7-k); ~k == 7-k for a 3-bit index.
  assign nidx     = idx_q + 3'd1;
  assign rx_sh    = {~idx_q, 3'b000};
  assign tx_sh    = {~nidx, 3'b000};
  assign tx_shift = res_q >> tx_sh;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    blk_d   = blk_q;
    res_d   = res_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            dec_d   = (rx_data == 8'h02);
            idx_d   = 3'd0;
            state_d = S_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (frame_abort) begin
          idx_d   = 3'd0;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          blk_d = (blk_q & ~(64'hFF << rx_sh))
                | ({56'b0, rx_data} << rx_sh);
          idx_d = nidx;
          if (idx_q == 3'd7) state_d = S_START;
        end
      end
      S_START: begin
        if (!des_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (des_done) begin
          res_d   = des_block_out;
          wdata_d = des_block_out[63:56];
          idx_d   = 3'd0;
          state_d = S_SEND;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: begin
        if (!fifo_full) begin
          idx_d   = nidx;
          wdata_d = tx_shift[7:0];
          if (idx_q == 3'd7) begin
            fcnt_d  = fcnt_q + 8'd1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      blk_q   <= 64'd0;
      res_q   <= 64'd0;
      wdata_q <= 8'd0;
      err_q   <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // rx_ready is gated by rst so it reads 0 while reset is held.
  assign rx_ready = ~rst
                  & (state_q == S_IDLE || state_q == S_RECV);
  assign busy     = (state_q != S_IDLE);
  assign des_start = (state_q == S_START) & ~des_busy;
  // The strobe is qualified by the live fifo_full so no write is
  // ever presented while the FIFO is full; the data is a flop.
  assign write_enable = (state_q == S_SEND) & ~fifo_full;
  assign write_data   = wdata_q;
  assign des_decrypt  = dec_q;
  assign des_block_in = blk_q;
  assign err          = err_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_tdes_frame_sched.sv
// Directed bench for tdes_frame_sched: frame table plus hand sequences
// for abort, stall, reset-in-SEND, counter wrap and watchdog timeout.
module tb_tdes_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        frame_abort = 1'b0;
  logic        des_start;
  logic        des_decrypt;
  logic [63:0] des_block_in;
  logic        des_busy;
  logic        des_done = 1'b0;
  logic [63:0] des_block_out = 64'd0;
  logic        write_enable;
  logic [7:0]  write_data;
  logic        fifo_full = 1'b0;
  logic        busy;
  logic        err;
  logic [7:0]  frame_count;

  logic [7:0]  to_rx_data = 8'd0;
  logic        to_rx_valid = 1'b0;
  logic        to_rx_ready, to_des_start, to_des_decrypt;
  logic [63:0] to_blk;
  logic        to_we, to_busy, to_err;
  logic [7:0]  to_wd, to_fc;

  always #5 clk = ~clk;

  tdes_frame_sched u_dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_abort(frame_abort),
    .des_start(des_start), .des_decrypt(des_decrypt),
    .des_block_in(des_block_in), .des_busy(des_busy),
    .des_done(des_done), .des_block_out(des_block_out),
    .write_enable(write_enable), .write_data(write_data),
    .fifo_full(fifo_full), .busy(busy), .err(err),
    .frame_count(frame_count)
  );

  tdes_frame_sched #(.TIMEOUT_CYCLES(16)) u_to (
    .clk(clk), .rst(rst),
    .rx_data(to_rx_data), .rx_valid(to_rx_valid),
    .rx_ready(to_rx_ready), .frame_abort(1'b0),
    .des_start(to_des_start), .des_decrypt(to_des_decrypt),
    .des_block_in(to_blk), .des_busy(1'b0),
    .des_done(1'b0), .des_block_out(64'd0),
    .write_enable(to_we), .write_data(to_wd),
    .fifo_full(1'b0), .busy(to_busy), .err(to_err),
    .frame_count(to_fc)
  );

  // DES core model: fixed latency, returns des_resp.
  int          des_lat = 20;
  logic [63:0] des_resp = 64'd0;
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic        busy_force = 1'b0;
  assign des_busy = m_busy | busy_force;

  always @(posedge clk) begin
    des_done <= 1'b0;
    if (rst) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
    end else if (des_start) begin
      m_cnt  <= des_lat;
      m_busy <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        des_done      <= 1'b1;
        m_busy        <= 1'b0;
        des_block_out <= des_resp;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Back-pressure: FIFO full during SEND cycles 3..6.
  logic bp_en = 1'b0;
  int   done_cyc = -100;
  always @(posedge clk) begin
    #1;
    fifo_full <= bp_en && (cyc >= done_cyc + 3) && (cyc <= done_cyc + 6);
  end

  // Monitor, sampled mid-cycle.
  logic [7:0] wq_b[$];
  int         wq_c[$];
  int viol = 0, n_start = 0, start_cyc = 0, n_err = 0;
  int n_fc = 0, fc_cyc = 0, to_nwe = 0;
  logic [7:0] prev_fc = 8'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable) begin
        wq_b.push_back(write_data);
        wq_c.push_back(cyc);
      end
      if (write_enable && fifo_full) viol <= viol + 1;
      if (des_start) begin
        n_start   <= n_start + 1;
        start_cyc <= cyc;
      end
      if (des_done) done_cyc <= cyc;
      if (err) n_err <= n_err + 1;
      if (frame_count != prev_fc) begin
        n_fc   <= n_fc + 1;
        fc_cyc <= cyc;
      end
      if (to_we) to_nwe <= to_nwe + 1;
    end
    prev_fc <= frame_count;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] fc_exp = 8'd0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic nsync;
    @(negedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b, input logic ab);
    rx_valid    = 1'b1;
    rx_data     = b;
    frame_abort = ab;
    @(posedge clk);
    #1;
    rx_valid    = 1'b0;
    frame_abort = 1'b0;
  endtask

  task automatic to_rx(input logic [7:0] b);
    to_rx_valid = 1'b1;
    to_rx_data  = b;
    @(posedge clk);
    #1;
    to_rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [63:0] data;
    logic [63:0] resp;
    int          lat;
    logic        bad;
    logic        dec;
    logic        bp;
    logic        stall;
  } vec_t;

  task automatic do_frame(input string nm, input vec_t v);
    int s0, e0, f0, w0, v0, nw, last, exp_s, lastw;
    logic [63:0] got;
    s0 = n_start; e0 = n_err; f0 = n_fc;
    w0 = wq_b.size(); v0 = viol;
    bp_en = v.bp; des_lat = v.lat; des_resp = v.resp;
    rx(v.cmd, 1'b0);
    if (v.bad) begin
      nsync;
      chk({nm, "_err"}, n_err - e0, 1);
      chk({nm, "_idle"}, {busy, rx_ready}, 2'b01);
      return;
    end
    last = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && v.stall) busy_force = 1'b1;
      last = cyc;
      rx(v.data[63-8*k -: 8], 1'b0);
    end
    exp_s = last + 1;
    if (v.stall) begin
      repeat (4) nsync;
      chk({nm, "_stall_nostart"}, n_start - s0, 0);
      chk({nm, "_stall_busy"}, busy, 1);
      @(posedge clk);
      #1;
      busy_force = 1'b0;
      exp_s = cyc;
    end
    for (int i = 0; i < 20 && n_start == s0; i++) nsync;
    chk({nm, "_start_cyc"}, start_cyc, exp_s);
    chk({nm, "_block_in"}, des_block_in, v.data);
    chk({nm, "_decrypt"}, des_decrypt, v.dec);
    for (int i = 0; i < 300 && n_fc == f0; i++) nsync;
    fc_exp = fc_exp + 8'd1;
    nw = wq_b.size() - w0;
    got = 64'd0;
    for (int i = 0; i < 8 && i < nw; i++)
      got = {got[55:0], wq_b[w0+i]};
    chk({nm, "_nwrites"}, nw, 8);
    chk({nm, "_tx_bytes"}, got, v.resp);
    lastw = v.bp ? 12 : 8;
    if (nw >= 8) begin
      chk({nm, "_first_we"}, wq_c[w0], done_cyc + 1);
      chk({nm, "_last_we"}, wq_c[w0+7], done_cyc + lastw);
    end
    chk({nm, "_fc_cyc"}, fc_cyc, done_cyc + lastw + 1);
    chk({nm, "_frame_count"}, frame_count, fc_exp);
    chk({nm, "_rx_ready"}, rx_ready, 1);
    chk({nm, "_no_full_wr"}, viol - v0, 0);
    chk({nm, "_one_start"}, n_start - s0, 1);
    chk({nm, "_no_err"}, n_err - e0, 0);
    bp_en = 1'b0;
  endtask

  vec_t vt[8];
  vec_t va;

  initial begin
    int s0, e0, f0, st;
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int s0, e0, f0, st;
    vt[0] = '{8'h01, 64'h0102030405060708, 64'hA1A2A3A4A5A6A7A8,
              20, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h7F, 64'd0, 64'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{8'h02, 64'h1122334455667788, 64'h0F1E2D3C4B5A6978,
              5, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'h01, 64'hDEADBEEFCAFEF00D, 64'h8000000000000001,
              3, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h00, 64'd0, 64'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'hFF, 64'd0, 64'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6] = '{8'h02, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000,
              1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{8'h01, 64'h0011223344556677, 64'h7766554433221100,
              2, 1'b0, 1'b0, 1'b0, 1'b1};
    va    = '{8'h01, 64'h5A5A5A5A00000001, 64'hC3C3C3C3C3C3C3C3,
              4, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    nsync;
    chk("rst_outs", {rx_ready, busy, des_start, des_decrypt,
                     write_enable, err, frame_count, write_data},
        64'd0);
    chk("rst_block", des_block_in, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nsync;
    chk("rst_rx_ready", {rx_ready, busy}, 2'b10);

    for (int i = 0; i < 8; i++)
      do_frame($sformatf("vec%0d", i), vt[i]);

    s0 = n_start; e0 = n_err;
    rx(8'h01, 1'b0);
    for (int k = 0; k < 4; k++) rx(8'(k + 1), 1'b0);
    rx(8'h55, 1'b1);
    nsync;
    chk("abort_idle", {busy, rx_ready}, 2'b01);
    chk("abort_no_err", n_err - e0, 0);
    repeat (5) nsync;
    chk("abort_no_start", n_start - s0, 0);
    do_frame("after_abort", va);

    des_lat = 2;
    des_resp = 64'h0123456789ABCDEF;
    st = wq_b.size();
    rx(8'h01, 1'b0);
    for (int k = 0; k < 8; k++) rx(8'hEE, 1'b0);
    for (int i = 0; i < 60 && wq_b.size() - st < 3; i++) nsync;
    chk("sendrst_in_send", busy, 1);
    rst = 1'b1;
    nsync;
    chk("sendrst_outs", {rx_ready, busy, des_start, des_decrypt,
                         write_enable, err, frame_count, write_data},
        64'd0);
    chk("sendrst_block", des_block_in, 64'd0);
    rst = 1'b0;
    fc_exp = 8'd0;
    nsync;
    chk("sendrst_ready", {rx_ready, busy}, 2'b10);

    des_lat = 1;
    for (int f = 0; f < 256; f++) begin
      f0 = n_fc;
      rx(8'h01, 1'b0);
      for (int k = 0; k < 8; k++) rx(8'(f), 1'b0);
      for (int i = 0; i < 60 && n_fc == f0; i++) nsync;
      if (f == 254) chk("wrap_255", frame_count, 8'd255);
    end
    chk("wrap_0", frame_count, 8'd0);

    to_rx(8'h01);
    for (int k = 0; k < 8; k++) to_rx(8'(k));
    nsync;
    chk("to_start", to_des_start, 1);
    repeat (16) nsync;
    chk("to_wait16", {to_busy, to_err}, 2'b10);
    nsync;
    chk("to_err", {to_busy, to_err}, 2'b01);
    repeat (3) nsync;
    chk("to_err_once", to_err, 0);
    chk("to_no_writes", to_nwe, 0);
    chk("to_fc", to_fc, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
